cu_vertex_cache_arbiter_control: RTL

- Shares one vertex cache lookup port among NUM_REQ compute-unit requesters using round-robin arbitration.
- Limits in-flight lookups with a credit counter and routes each completion back to its requester by ID tag.
- Provides a drain sequence so the cache is quiescent before reconfiguration or flush.
- Sits between the per-CU read command sources and the vertex cache pipeline, which returns exactly one completion (hit response or forwarded miss) per issued lookup.

---
 rtl/cu_vertex_cache_arbiter_control.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cu_vertex_cache_arbiter_control.sv
// Round-robin arbiter sharing one vertex cache lookup port among NUM_REQ requesters,
// with credit-limited issue, tag-routed completions and a drain sequence.
module cu_vertex_cache_arbiter_control #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = 32,
  parameter int ID_W            = $clog2(NUM_REQ),
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clock,
  input  logic                      rst_in,
  input  logic                      enabled_in,
  input  logic                      drain_in,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]        req_ready_out,
  output logic                      cache_cmd_valid_out,
  output logic [ADDR_W-1:0]         cache_cmd_addr_out,
  output logic [ID_W-1:0]           cache_cmd_id_out,
  input  logic                      cache_done_valid_in,
  input  logic [ID_W-1:0]           cache_done_id_in,
  output logic [NUM_REQ-1:0]        rsp_valid_out,
  output logic [CNT_W-1:0]          outstanding_out,
  output logic [1:0]                state_out,
  output logic                      drained_out,
  output logic                      err_underflow_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e               state_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 cmd_valid_q;
  logic [ADDR_W-1:0]    cmd_addr_q;
  logic [ID_W-1:0]      cmd_id_q;
  logic [NUM_REQ-1:0]   rsp_q, rsp_d;
  logic                 drained_q;

  logic                 grant_en;
  logic                 found;
  logic [ID_W-1:0]      idx;
  logic [ID_W-1:0]      win_id;
  logic [NUM_REQ-1:0]   grant;

  // Credits are judged on the registered count only, so a completion in the
  // same cycle never lets an extra lookup through.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant    = '0;
    found    = 1'b0;
    win_id   = '0;
    idx      = '0;
    grant_en = (state_q == ST_RUN) && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = rr_ptr_q + ID_W'(i);
      if (grant_en && !found && req_valid_in[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
    if (found) grant[win_id] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (found && !cache_done_valid_in) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (cache_done_valid_in && !found) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
    rsp_d = '0;
    rsp_d[cache_done_id_in] = cache_done_valid_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_id_q    <= '0;
      rsp_q       <= '0;
      drained_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_q       <= rsp_d;
      cmd_valid_q <= found;
      drained_q   <= 1'b0;
      if (found) begin
        cmd_addr_q <= req_addr_in[win_id*ADDR_W +: ADDR_W];
        cmd_id_q   <= win_id;
        rr_ptr_q   <= win_id + ID_W'(1);
      end
      unique case (state_q)
        ST_IDLE:  if (enabled_in && !drain_in) state_q <= ST_RUN;
        ST_RUN:   if (drain_in || !enabled_in) state_q <= ST_DRAIN;
        ST_DRAIN: if (cnt_q == '0) begin
          state_q   <= ST_IDLE;
          drained_q <= 1'b1;
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_out       = grant;
  assign cache_cmd_valid_out = cmd_valid_q;
  assign cache_cmd_addr_out  = cmd_addr_q;
  assign cache_cmd_id_out    = cmd_id_q;
  assign rsp_valid_out       = rsp_q;
  assign outstanding_out     = cnt_q;
  assign state_out           = state_q;
  assign drained_out         = drained_q;
  assign err_underflow_out   = err_q;

endmodule
